// File: rtl/rx_frame_chk.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rx_frame_chk
// Description : UART receive-side frame checker. Deserialises mid-bit
//               samples (LSB first), checks parity (none/even/odd/mark/
//               space), validates one or two stop bits and reports
//               per-frame error flags, a sticky parity flag and a
//               saturating errored-frame counter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK            in   system clock, rising edge
//   RST            in   asynchronous active-low reset
//   Frame_Start    in   start bit confirmed; next Sample_En is data bit 0
//   Sample_En      in   Sbit holds a valid mid-bit sample
//   Sbit           in   sampled serial bit
//   PAR_EN         in   parity bit present
//   PAR_TYP        in   00 even, 01 odd, 10 mark, 11 space
//   STP_2          in   two stop bits expected
//   Clr_Err        in   clears Par_Err_Sticky and Err_Cnt
//   P_DATA         out  recovered data word
//   Data_Valid     out  one-cycle frame-complete pulse
//   Par_Err        out  parity error in last completed frame
//   Stp_Err        out  stop-bit error in last completed frame
//   Par_Err_Sticky out  set by any parity error until cleared
//   Err_Cnt        out  saturating count of errored frames
//   Busy           out  frame reception in progress
// ============================================================================
module rx_frame_chk #(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Frame_Start,
    input  logic                     Sample_En,
    input  logic                     Sbit,
    input  logic                     PAR_EN,
    input  logic [1:0]               PAR_TYP,
    input  logic                     STP_2,
    input  logic                     Clr_Err,
    output logic [DATA_WIDTH-1:0]    P_DATA,
    output logic                     Data_Valid,
    output logic                     Par_Err,
    output logic                     Stp_Err,
    output logic                     Par_Err_Sticky,
    output logic [ERR_CNT_WIDTH-1:0] Err_Cnt,
    output logic                     Busy
);

    localparam int c_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [c_CNT_W-1:0]       c_LAST_BIT = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [ERR_CNT_WIDTH-1:0] c_CNT_MAX  = {ERR_CNT_WIDTH{1'b1}};

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_DATA   = 3'd1;
    localparam logic [2:0] c_PARITY = 3'd2;
    localparam logic [2:0] c_STOP1  = 3'd3;
    localparam logic [2:0] c_STOP2  = 3'd4;

    logic [2:0]               r_state;
    logic [2:0]               w_next_state;

    logic [c_CNT_W-1:0]       r_bit_cnt;
    logic [DATA_WIDTH-1:0]    r_shreg;
    logic                     r_acc;
    logic                     r_par_err;
    logic                     r_stp_err;
    logic                     r_cfg_par_en;
    logic [1:0]               r_cfg_par_typ;
    logic                     r_cfg_stp2;

    // A sample only counts when no Frame_Start is present in the same cycle.
    logic                     w_smp;
    logic                     w_shift;
    logic                     w_par_smp;
    logic                     w_stop1_smp;
    logic                     w_done;
    logic                     w_par_exp;
    logic                     w_stp_err_final;
    logic                     w_sticky_base;
    logic [ERR_CNT_WIDTH-1:0] w_cnt_base;
    logic                     w_sticky_next;
    logic [ERR_CNT_WIDTH-1:0] w_cnt_next;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; Frame_Start restarts from any state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (Frame_Start) begin
            w_next_state = c_DATA;
        end else if (Sample_En) begin
            case (r_state)
                c_DATA: begin
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_next_state = r_cfg_par_en ? c_PARITY : c_STOP1;
                    end
                end
                c_PARITY: w_next_state = c_STOP1;
                c_STOP1:  w_next_state = r_cfg_stp2 ? c_STOP2 : c_IDLE;
                c_STOP2:  w_next_state = c_IDLE;
                default:  w_next_state = c_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_smp       = Sample_En & ~Frame_Start;
        w_shift     = w_smp && (r_state == c_DATA);
        w_par_smp   = w_smp && (r_state == c_PARITY);
        w_stop1_smp = w_smp && (r_state == c_STOP1);
        w_done      = w_smp && (((r_state == c_STOP1) && !r_cfg_stp2) ||
                                 (r_state == c_STOP2));

        case (r_cfg_par_typ)
            2'b00:   w_par_exp = r_acc;
            2'b01:   w_par_exp = ~r_acc;
            2'b10:   w_par_exp = 1'b1;
            default: w_par_exp = 1'b0;
        endcase

        w_stp_err_final = (r_state == c_STOP2) ? (r_stp_err | ~Sbit) : ~Sbit;

        // Clear is applied before the completing frame's contribution.
        w_sticky_base = Clr_Err ? 1'b0 : Par_Err_Sticky;
        w_cnt_base    = Clr_Err ? '0 : Err_Cnt;
        w_sticky_next = w_sticky_base;
        w_cnt_next    = w_cnt_base;
        if (w_done) begin
            w_sticky_next = w_sticky_base | r_par_err;
            if ((r_par_err || w_stp_err_final) && (w_cnt_base != c_CNT_MAX)) begin
                w_cnt_next = w_cnt_base + ERR_CNT_WIDTH'(1);
            end
        end
    end

    assign Busy = (r_state != c_IDLE);

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_bit_cnt      <= '0;
            r_shreg        <= '0;
            r_acc          <= 1'b0;
            r_par_err      <= 1'b0;
            r_stp_err      <= 1'b0;
            r_cfg_par_en   <= 1'b0;
            r_cfg_par_typ  <= 2'b00;
            r_cfg_stp2     <= 1'b0;
            P_DATA         <= '0;
            Data_Valid     <= 1'b0;
            Par_Err        <= 1'b0;
            Stp_Err        <= 1'b0;
            Par_Err_Sticky <= 1'b0;
            Err_Cnt        <= '0;
        end else begin
            Data_Valid     <= w_done;
            Par_Err_Sticky <= w_sticky_next;
            Err_Cnt        <= w_cnt_next;

            if (Frame_Start) begin
                r_bit_cnt     <= '0;
                r_acc         <= 1'b0;
                r_par_err     <= 1'b0;
                r_stp_err     <= 1'b0;
                r_cfg_par_en  <= PAR_EN;
                r_cfg_par_typ <= PAR_TYP;
                r_cfg_stp2    <= STP_2;
            end

            // Right shift: after DATA_WIDTH samples bit 0 is the first bit.
            if (w_shift) begin
                r_shreg   <= {Sbit, r_shreg[DATA_WIDTH-1:1]};
                r_acc     <= r_acc ^ Sbit;
                r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
            end

            if (w_par_smp) begin
                r_par_err <= (Sbit != w_par_exp);
            end

            if (w_stop1_smp) begin
                r_stp_err <= ~Sbit;
            end

            if (w_done) begin
                P_DATA  <= r_shreg;
                Par_Err <= r_par_err;
                Stp_Err <= w_stp_err_final;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_chk.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rx_frame_chk
// Description : Scoreboard bench for rx_frame_chk. Instance 0 uses
//               DATA_WIDTH=8 / ERR_CNT_WIDTH=2, instance 1 uses
//               DATA_WIDTH=5 / ERR_CNT_WIDTH=8. Expected frame results are
//               queued as frames are driven and compared on Data_Valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_frame_chk;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    logic       fs   [2];
    logic       se   [2];
    logic       sb   [2];
    logic       pen  [2];
    logic [1:0] ptyp [2];
    logic       stp2 [2];
    logic       clr  [2];

    logic [7:0] a_pdata;
    logic       a_dv, a_perr, a_serr, a_sticky, a_busy;
    logic [1:0] a_cnt;
    logic [4:0] b_pdata;
    logic       b_dv, b_perr, b_serr, b_sticky, b_busy;
    logic [7:0] b_cnt;

    rx_frame_chk #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(2)) u_dut_a (
        .CLK(CLK), .RST(RST), .Frame_Start(fs[0]), .Sample_En(se[0]), .Sbit(sb[0]),
        .PAR_EN(pen[0]), .PAR_TYP(ptyp[0]), .STP_2(stp2[0]), .Clr_Err(clr[0]),
        .P_DATA(a_pdata), .Data_Valid(a_dv), .Par_Err(a_perr), .Stp_Err(a_serr),
        .Par_Err_Sticky(a_sticky), .Err_Cnt(a_cnt), .Busy(a_busy)
    );

    rx_frame_chk #(.DATA_WIDTH(5), .ERR_CNT_WIDTH(8)) u_dut_b (
        .CLK(CLK), .RST(RST), .Frame_Start(fs[1]), .Sample_En(se[1]), .Sbit(sb[1]),
        .PAR_EN(pen[1]), .PAR_TYP(ptyp[1]), .STP_2(stp2[1]), .Clr_Err(clr[1]),
        .P_DATA(b_pdata), .Data_Valid(b_dv), .Par_Err(b_perr), .Stp_Err(b_serr),
        .Par_Err_Sticky(b_sticky), .Err_Cnt(b_cnt), .Busy(b_busy)
    );

    typedef struct {
        int   data;
        logic perr;
        logic serr;
        logic sticky;
        int   cnt;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t r_ea;
    exp_t r_eb;

    int n_chk  = 0;
    int n_pass = 0;
    int m_cnt    [2];
    bit m_sticky [2];

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int dw_of(input int i);
        return (i == 0) ? 8 : 5;
    endfunction

    function automatic int cmax_of(input int i);
        return (i == 0) ? 3 : 255;
    endfunction

    function automatic logic busy_of(input int i);
        return (i == 0) ? a_busy : b_busy;
    endfunction

    function automatic logic dv_of(input int i);
        return (i == 0) ? a_dv : b_dv;
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic bit_out(input int i, input logic b);
        repeat ($urandom_range(0, 2)) tick();
        se[i] = 1'b1;
        sb[i] = b;
        tick();
        se[i] = 1'b0;
    endtask

    // Drive one complete frame and queue its expected result.
    task automatic send(input int i, input int data, input logic p_en,
                        input logic [1:0] typ, input logic s2, input logic pbit,
                        input logic st1, input logic st2, input logic clr_last);
        exp_t e;
        logic acc;
        logic pexp;
        int   w;
        w   = dw_of(i);
        acc = 1'b0;
        for (int k = 0; k < w; k++) acc ^= data[k];
        case (typ)
            2'd0:    pexp = acc;
            2'd1:    pexp = ~acc;
            2'd2:    pexp = 1'b1;
            default: pexp = 1'b0;
        endcase
        e.data = data & ((1 << w) - 1);
        e.perr = p_en && (pbit != pexp);
        e.serr = !st1 || (s2 && !st2);
        if (clr_last) begin
            m_cnt[i]    = 0;
            m_sticky[i] = 1'b0;
        end
        if (e.perr) m_sticky[i] = 1'b1;
        if ((e.perr || e.serr) && (m_cnt[i] < cmax_of(i))) m_cnt[i]++;
        e.sticky = m_sticky[i];
        e.cnt    = m_cnt[i];
        if (i == 0) q_a.push_back(e);
        else        q_b.push_back(e);

        // Frame_Start with a coincident sample that must be discarded.
        fs[i]   = 1'b1;
        se[i]   = 1'b1;
        sb[i]   = 1'b1;
        pen[i]  = p_en;
        ptyp[i] = typ;
        stp2[i] = s2;
        tick();
        fs[i] = 1'b0;
        se[i] = 1'b0;
        check("busy_after_start", busy_of(i), 1);
        // Config changes mid-frame must not affect this frame.
        pen[i]  = ~p_en;
        stp2[i] = ~s2;
        ptyp[i] = ~typ;
        for (int k = 0; k < w; k++) bit_out(i, data[k]);
        if (p_en) bit_out(i, pbit);
        if (s2) begin
            bit_out(i, st1);
            check("dv_before_stop2", dv_of(i), 0);
        end
        se[i]  = 1'b1;
        sb[i]  = s2 ? st2 : st1;
        clr[i] = clr_last;
        tick();
        se[i]  = 1'b0;
        clr[i] = 1'b0;
        check("busy_at_done", busy_of(i), 0);
    endtask

    task automatic abort_after(input int i, input int n);
        fs[i] = 1'b1;
        tick();
        fs[i] = 1'b0;
        for (int k = 0; k < n; k++) bit_out(i, logic'($urandom_range(0, 1)));
    endtask

    task automatic clear_err(input int i);
        clr[i] = 1'b1;
        tick();
        clr[i] = 1'b0;
        m_cnt[i]    = 0;
        m_sticky[i] = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (RST && a_dv) begin
            if (q_a.size() == 0) begin
                check("a_dv_unexpected", 1, 0);
            end else begin
                r_ea = q_a.pop_front();
                check("a_pdata",  a_pdata,  r_ea.data);
                check("a_perr",   a_perr,   r_ea.perr);
                check("a_serr",   a_serr,   r_ea.serr);
                check("a_sticky", a_sticky, r_ea.sticky);
                check("a_cnt",    a_cnt,    r_ea.cnt);
            end
        end
        if (RST && b_dv) begin
            if (q_b.size() == 0) begin
                check("b_dv_unexpected", 1, 0);
            end else begin
                r_eb = q_b.pop_front();
                check("b_pdata",  b_pdata,  r_eb.data);
                check("b_perr",   b_perr,   r_eb.perr);
                check("b_serr",   b_serr,   r_eb.serr);
                check("b_sticky", b_sticky, r_eb.sticky);
                check("b_cnt",    b_cnt,    r_eb.cnt);
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            fs[i] = 1'b0; se[i] = 1'b0; sb[i] = 1'b1; pen[i] = 1'b0;
            ptyp[i] = 2'b00; stp2[i] = 1'b0; clr[i] = 1'b0;
            m_cnt[i] = 0; m_sticky[i] = 1'b0;
        end
        repeat (3) tick();
        check("rst_a_pdata", a_pdata, 0);
        check("rst_a_dv",    a_dv,    0);
        check("rst_a_cnt",   a_cnt,   0);
        check("rst_a_busy",  a_busy,  0);
        check("rst_b_sticky", b_sticky, 0);
        check("rst_b_busy",  b_busy,  0);
        RST = 1'b1;
        tick();

        // Sample_En in IDLE without Frame_Start is ignored.
        se[0] = 1'b1;
        repeat (3) tick();
        se[0] = 1'b0;
        check("idle_sample_busy", a_busy, 0);

        // Instance 0: DATA_WIDTH=8, ERR_CNT_WIDTH=2
        send(0, 'hA5, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send(0, 'h3C, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send(0, 'h3C, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        clear_err(0);
        check("clr_a_sticky", a_sticky, 0);
        check("clr_a_cnt",    a_cnt,    0);
        send(0, 'h00, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        clear_err(0);
        repeat (5) send(0, int'($urandom_range(0, 255)), 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("sat_a_cnt", a_cnt, 3);
        abort_after(0, 4);
        send(0, 'h5A, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send(0, 'hC3, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset in the middle of DATA.
        abort_after(0, 3);
        #2;
        RST = 1'b0;
        #1;
        check("mid_rst_a_pdata",  a_pdata,  0);
        check("mid_rst_a_cnt",    a_cnt,    0);
        check("mid_rst_a_sticky", a_sticky, 0);
        check("mid_rst_a_perr",   a_perr,   0);
        check("mid_rst_a_busy",   a_busy,   0);
        m_cnt[0] = 0; m_sticky[0] = 1'b0;
        m_cnt[1] = 0; m_sticky[1] = 1'b0;
        tick();
        RST = 1'b1;
        tick();

        // Instance 1: DATA_WIDTH=5, ERR_CNT_WIDTH=8
        send(1, 'h15, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send(1, 'h0A, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        send(1, 'h1F, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        send(1, 'h03, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        send(1, 'h12, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        repeat (4) tick();
        check("a_sb_drained", q_a.size(), 0);
        check("b_sb_drained", q_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
